// File: rtl/sar_search_ctrl_if.sv
// Handshake and comparator-facing signals of the successive-approximation search controller.
// The slave modport is the controller side; the master modport is the requester/comparator side.
interface sar_search_ctrl_if #(
    parameter int WIDTH = 3
);
    logic             start;
    logic [WIDTH-1:0] trial;
    logic             cmp_gt;
    logic             cmp_lt;
    logic             cmp_eq;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             found;
    logic             err;

    modport slave (
        input  start, cmp_gt, cmp_lt, cmp_eq,
        output trial, busy, done, result, found, err
    );

    modport master (
        output start, cmp_gt, cmp_lt, cmp_eq,
        input  trial, busy, done, result, found, err
    );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: binary-searches an unknown target MSB first
// by driving trial words into an external magnitude comparator and reading GT/LT/EQ back.
module sar_search_ctrl #(
    parameter int WIDTH   = 3,
    parameter int CMP_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    sar_search_ctrl_if.slave   bus
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, VERIFY, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic             err_q, err_d;

    logic sample;
    logic onehot;

    // cmp_* are only trusted on the CMP_LAT-th edge after the trial last changed.
    assign sample = (cnt_q == CW'(CMP_LAT - 1));
    assign onehot = ( bus.cmp_gt & ~bus.cmp_lt & ~bus.cmp_eq) |
                    (~bus.cmp_gt &  bus.cmp_lt & ~bus.cmp_eq) |
                    (~bus.cmp_gt & ~bus.cmp_lt &  bus.cmp_eq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            trial_q  <= '0;
            result_q <= '0;
            bit_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        result_d = result_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        found_d  = found_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    trial_d = WIDTH'(1) << (WIDTH - 1);
                    bit_d   = BW'(WIDTH - 1);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    found_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (!sample) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (!onehot) begin
                    err_d    = 1'b1;
                    found_d  = 1'b0;
                    result_d = trial_q;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else if (bus.cmp_eq) begin
                    result_d = trial_q;
                    found_d  = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    // trial > target clears the bit under test, trial < target keeps it
                    trial_d[bit_q] = bus.cmp_lt;
                    cnt_d          = '0;
                    if (bit_q != '0) begin
                        trial_d[bit_q - BW'(1)] = 1'b1;
                        bit_d                   = bit_q - BW'(1);
                    end else begin
                        state_d = VERIFY;
                    end
                end
            end

            VERIFY: begin
                if (!sample) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    err_d    = ~onehot;
                    found_d  = onehot & bus.cmp_eq;
                    result_d = trial_q;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.trial  = trial_q;
    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.found  = found_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench for sar_search_ctrl: one instance with a combinational comparator,
// one with CMP_LAT=3, both fed by a behavioural comparator against a bench target.
module tb_sar_search_ctrl;
    logic clk;
    logic rst_n;
    logic [2:0] tgt1, tgt3;
    logic bad1;
    int ncmp = 0;
    int nerr = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sar_search_ctrl_if #(.WIDTH(3)) b1 ();
    sar_search_ctrl_if #(.WIDTH(3)) b3 ();

    assign b1.cmp_gt = bad1 | (b1.trial > tgt1);
    assign b1.cmp_lt = bad1 | (b1.trial < tgt1);
    assign b1.cmp_eq = ~bad1 & (b1.trial == tgt1);
    assign b3.cmp_gt = (b3.trial > tgt3);
    assign b3.cmp_lt = (b3.trial < tgt3);
    assign b3.cmp_eq = (b3.trial == tgt3);

    sar_search_ctrl #(.WIDTH(3), .CMP_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    sar_search_ctrl #(.WIDTH(3), .CMP_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    task automatic chk(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // start held for exactly one edge (edge s); returns 1ns after edge s
    task automatic pulse1();
        @(negedge clk);
        b1.start = 1'b1;
        @(posedge clk);
        #1;
        b1.start = 1'b0;
    endtask

    // edges after s until done is seen; -1 if it never comes
    task automatic wait_done1(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (b1.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run1(input string tag, input int t, input int exp_lat,
                        input int exp_res, input int exp_found, input int exp_err);
        int lat;
        tgt1 = 3'(t);
        pulse1();
        chk({tag, ".busy_at_s"}, int'(b1.busy), 1);
        wait_done1(lat);
        chk({tag, ".latency"}, lat, exp_lat);
        chk({tag, ".result"}, int'(b1.result), exp_res);
        chk({tag, ".found"}, int'(b1.found), exp_found);
        chk({tag, ".err"}, int'(b1.err), exp_err);
        chk({tag, ".busy_at_done"}, int'(b1.busy), 0);
        @(posedge clk);
        #1;
        chk({tag, ".done_one_cycle"}, int'(b1.done), 0);
        chk({tag, ".result_held"}, int'(b1.result), exp_res);
    endtask

    initial begin
        int lat, ndone, done_at, res_at, fnd_at, mask;
        logic [2:0] prev;
        rst_n    = 1'b0;
        b1.start = 1'b0;
        b3.start = 1'b0;
        tgt1     = 3'd0;
        tgt3     = 3'd0;
        bad1     = 1'b0;
        #1;
        chk("reset.trial", int'(b1.trial), 0);
        chk("reset.busy", int'(b1.busy), 0);
        chk("reset.done", int'(b1.done), 0);
        chk("reset.result", int'(b1.result), 0);
        chk("reset.found_err", int'({b1.found, b1.err}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // trials 4(lt) 6(gt) 5(eq)
        run1("t5", 5, 3, 5, 1, 0);
        chk("t5.trial_held", int'(b1.trial), 5);
        // trials 4,2,1 all gt, then verify 0
        run1("t0", 0, 4, 0, 1, 0);
        // 4(lt) then 6(eq): early exit
        run1("t6", 6, 2, 6, 1, 0);
        // gt and lt both high at the first sample
        bad1 = 1'b1;
        run1("bad", 3, 1, 4, 0, 1);
        bad1 = 1'b0;

        // CMP_LAT=3, T=0, start held while busy
        tgt3 = 3'd0;
        prev = b3.trial;
        @(negedge clk);
        b3.start = 1'b1;
        @(posedge clk);
        #1;
        chk("lat3.trial_at_s", int'(b3.trial), 4);
        prev = b3.trial;
        b3.start = b3.busy;
        ndone = 0; done_at = -1; res_at = -1; fnd_at = -1; mask = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (b3.trial !== prev) mask |= (1 << e);
            prev = b3.trial;
            if (b3.done) begin
                ndone++;
                done_at = e;
                res_at  = int'(b3.result);
                fnd_at  = int'(b3.found);
            end
            b3.start = b3.busy;
        end
        b3.start = 1'b0;
        chk("lat3.done_count", ndone, 1);
        chk("lat3.done_edge", done_at, 12);
        chk("lat3.result", res_at, 0);
        chk("lat3.found", fnd_at, 1);
        chk("lat3.trial_change_edges", mask, 32'h248);

        // reset in the middle of a search
        tgt1 = 3'd5;
        pulse1();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst.busy_before", int'(b1.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rst.trial", int'(b1.trial), 0);
        chk("rst.result", int'(b1.result), 0);
        chk("rst.flags", int'({b1.busy, b1.done, b1.found, b1.err}), 0);
        ndone = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (b1.done) ndone++;
        end
        chk("rst.no_done", ndone, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run1("post_rst", 5, 3, 5, 1, 0);

        // start ignored while in DONE: a pulse landing on the DONE->IDLE edge
        tgt1 = 3'd7;
        pulse1();
        wait_done1(lat);
        chk("t7.latency", lat, 3);
        chk("t7.result", int'(b1.result), 7);
        b1.start = 1'b1;
        @(posedge clk);
        #1;
        b1.start = 1'b0;
        chk("t7.start_in_done_ignored", int'(b1.busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
